// File: rtl/load_tile_packer.sv
// load_tile_packer
//
// Feeds the tile buffer file. Each load command consumes up to CAPACITY input
// elements, packs them little-endian into TILE_WIDTH-bit tiles (element k of
// a tile lands in byte lane k), and always issues exactly TILE_COUNT tile
// writes. The last partial tile and any unused tiles are written as zero, so
// the buffer file's per-buffer tile index wraps back to 0 after every load.
//
// Handshake: an input element transfers on a rising clk edge where in_valid
// and in_ready are both high. in_ready never depends on in_valid. in_data
// must be stable while in_valid is high. in_valid is ignored outside PACK.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        load command strobe, sampled only in IDLE
//   dest_buffer  target buffer, latched on start
//   length       element count to consume, latched on start (clamped to CAPACITY)
//   in_valid     input element valid
//   in_data      input element
//   in_ready     block accepts in_data this cycle
//   write_enable one-cycle tile write strobe
//   write_data   packed tile (holds its value between writes)
//   write_buffer latched dest_buffer
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle pulse when a load completes
//   state_dbg    current FSM state (IDLE=0, PACK=1, PAD=2, FINISH=3)
module load_tile_packer #(
  parameter int BUFFER_WIDTH = 1024,
  parameter int BUFFER_COUNT = 2,
  parameter int TILE_WIDTH   = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 20,
  localparam int BUF_W = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BUF_W-1:0]      dest_buffer,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [TILE_WIDTH-1:0] write_data,
  output logic [BUF_W-1:0]      write_buffer,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  localparam int TILE_BYTES = TILE_WIDTH / DATA_WIDTH;
  localparam int TILE_COUNT = BUFFER_WIDTH / TILE_WIDTH;
  localparam int CAPACITY   = TILE_COUNT * TILE_BYTES;
  localparam int LANE_W     = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;
  localparam int CNT_W      = $clog2(CAPACITY + 1);
  localparam int TW_W       = $clog2(TILE_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PACK   = 2'd1,
    PAD    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state;
  logic [BUF_W-1:0]      buf_q;
  logic [CNT_W-1:0]      eff_len;
  logic [CNT_W-1:0]      accept_cnt;
  logic [LANE_W-1:0]     lane;
  logic [TW_W-1:0]       tiles_written;
  logic [TILE_WIDTH-1:0] acc;

  logic [CNT_W-1:0]      len_clamped;
  logic [CNT_W-1:0]      accept_cnt_inc;
  logic [TW_W-1:0]       tiles_written_inc;
  logic [TILE_WIDTH-1:0] acc_merged;
  logic                  accept;
  logic                  tile_full;
  logic                  last_elem;

  // Lengths beyond one buffer are truncated; the excess is never consumed.
  assign len_clamped = (length > LEN_WIDTH'(CAPACITY)) ? CNT_W'(CAPACITY)
                                                       : length[CNT_W-1:0];

  assign in_ready          = (state == PACK) && (accept_cnt < eff_len);
  assign accept            = in_valid && in_ready;
  assign accept_cnt_inc    = accept_cnt + CNT_W'(1);
  assign tiles_written_inc = tiles_written + TW_W'(1);
  assign tile_full         = (lane == LANE_W'(TILE_BYTES - 1));
  assign last_elem         = (accept_cnt_inc == eff_len);

  // Accumulator with the incoming element dropped into its byte lane. Lanes
  // above the current one are still zero because acc clears per tile.
  always_comb begin
    acc_merged = acc;
    acc_merged[int'(lane) * DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  assign write_buffer = buf_q;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      buf_q         <= '0;
      eff_len       <= '0;
      accept_cnt    <= '0;
      lane          <= '0;
      tiles_written <= '0;
      acc           <= '0;
      write_enable  <= 1'b0;
      write_data    <= '0;
      done          <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            buf_q         <= dest_buffer;
            eff_len       <= len_clamped;
            accept_cnt    <= '0;
            lane          <= '0;
            tiles_written <= '0;
            acc           <= '0;
            state         <= (len_clamped != '0) ? PACK : PAD;
          end
        end
        PACK: begin
          if (accept) begin
            accept_cnt <= accept_cnt_inc;
            if (tile_full || last_elem) begin
              // write_data is a separate register, so the next element can
              // be accepted into the cleared accumulator in the same cycle
              // the tile write is presented.
              write_enable  <= 1'b1;
              write_data    <= acc_merged;
              acc           <= '0;
              lane          <= '0;
              tiles_written <= tiles_written_inc;
              if (last_elem) begin
                state <= (tiles_written_inc < TW_W'(TILE_COUNT)) ? PAD : FINISH;
              end
            end else begin
              acc  <= acc_merged;
              lane <= lane + 1'b1;
            end
          end
        end
        PAD: begin
          write_enable  <= 1'b1;
          write_data    <= '0;
          tiles_written <= tiles_written_inc;
          if (tiles_written_inc == TW_W'(TILE_COUNT)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          // done is registered, so it appears the cycle after the final
          // tile write, while the FSM is already back in IDLE.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_tile_packer.sv
// Testbench for load_tile_packer: table of load commands with hand-computed
// spot values, a tile scoreboard fed from the byte stream, and hand-written
// sequences for reset-state and reset-mid-load.
module tb_load_tile_packer;

  localparam int TC  = 4;
  localparam int CAP = 128;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [0:0]   dest_buffer;
  logic [19:0]  length;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         write_enable;
  logic [255:0] write_data;
  logic [0:0]   write_buffer;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  load_tile_packer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dest_buffer  (dest_buffer),
    .length       (length),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_buffer (write_buffer),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int           errors = 0;
  int           checks = 0;
  logic [255:0] exp_q[$];
  logic [0:0]   exp_buf;
  int           got_cyc[$];
  int           load_wr;
  logic [255:0] tiles [TC];

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && write_enable) begin
      got_cyc.push_back(cyc);
      if (load_wr < TC) tiles[load_wr] = write_data;
      load_wr++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 256'(load_wr), 256'(0));
      end else begin
        check("tile_data", write_data, exp_q.pop_front());
        check("write_buffer", 256'(write_buffer), 256'(exp_buf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  // mode 0: in_valid held high; mode 1: in_valid pattern 1,0,0,1,0,0...
  // disrupt_at: after this many accepts, pulse start with the other buffer.
  typedef struct {
    int dest;
    int len;
    int mode;
    int base;
    int disrupt_at;
    int exp_acc;
    int t0_l0;
    int t1_l7;
    int t3_l31;
  } vec_t;

  vec_t vecs [7];

  // ---------------- driver tasks ----------------
  task automatic run_vec(input vec_t v);
    int n;
    int sent;
    int k;
    int bad_ready;
    int start_cyc;
    int done_cyc;
    bit done_seen;
    bit disrupted;
    int exp_wr_cyc[$];
    int exp_cyc[$];
    int nxt;
    logic [255:0] t;

    n = (v.len > CAP) ? CAP : v.len;
    exp_q.delete();
    got_cyc.delete();
    load_wr = 0;
    for (int i = 0; i < TC; i++) tiles[i] = 'x;
    for (int ti = 0; ti < TC; ti++) begin
      t = '0;
      for (int ln = 0; ln < 32; ln++) begin
        if (ti * 32 + ln < n) t[ln*8 +: 8] = 8'(v.base + ti * 32 + ln);
      end
      exp_q.push_back(t);
    end
    exp_buf = 1'(v.dest);

    @(negedge clk);
    start       = 1'b1;
    dest_buffer = 1'(v.dest);
    length      = 20'(v.len);
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));

    sent = 0; k = 0; bad_ready = 0; done_seen = 0; done_cyc = -1; disrupted = 0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end else begin
        if (in_ready && sent >= v.exp_acc) bad_ready++;
        in_valid = (v.mode == 0) ? 1'b1 : (k % 3 == 0);
        in_data  = 8'(v.base + sent);
        if (in_valid && in_ready) begin
          sent++;
          if (sent % 32 == 0 || sent == n) exp_wr_cyc.push_back(cyc + 1);
        end
        if (!disrupted && v.disrupt_at == sent) begin
          disrupted   = 1;
          start       = 1'b1;
          dest_buffer = 1'(1 - v.dest);
          length      = 20'd5;
        end else begin
          start = 1'b0;
        end
        k++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;

    check("done_seen", 256'(done_seen), 256'(1));
    check("accepts", 256'(sent), 256'(v.exp_acc));
    check("ready_after_len", 256'(bad_ready), 256'(0));

    exp_cyc = exp_wr_cyc;
    nxt = (exp_cyc.size() == 0) ? start_cyc + 2 : exp_cyc[exp_cyc.size()-1] + 1;
    while (exp_cyc.size() < TC) begin
      exp_cyc.push_back(nxt);
      nxt++;
    end
    for (int i = 0; i < TC; i++) begin
      check("write_cycle", 256'((got_cyc.size() > i) ? got_cyc[i] : -1),
            256'(exp_cyc[i]));
    end
    check("done_cycle", 256'(done_cyc), 256'(exp_cyc[TC-1] + 1));

    check("t0_lane0", 256'(tiles[0][7:0]), 256'(v.t0_l0));
    check("t1_lane7", 256'(tiles[1][63:56]), 256'(v.t1_l7));
    check("t3_lane31", 256'(tiles[3][255:248]), 256'(v.t3_l31));

    @(negedge clk);
    check("done_one_cycle", 256'(done), 256'(0));
    check("idle_after_done", 256'(busy), 256'(0));
    check("write_count", 256'(load_wr), 256'(TC));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 256'(in_ready), 256'(0));
    check({tag, "_write_enable"}, 256'(write_enable), 256'(0));
    check({tag, "_write_data"}, write_data, 256'(0));
    check({tag, "_write_buffer"}, 256'(write_buffer), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_state"}, 256'(state_dbg), 256'(0));
  endtask

  // Start a 128-element load, abort with reset after 10 accepts.
  task automatic reset_mid_load();
    int sent;
    int done_hits;
    exp_q.delete();
    load_wr = 0;
    @(negedge clk);
    start = 1'b1; dest_buffer = 1'b1; length = 20'd128;
    @(negedge clk);
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 50 && sent < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + sent);
      if (in_ready) sent++;
      @(negedge clk);
    end
    check("abort_accepts", 256'(sent), 256'(10));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    done_hits = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    check("abort_no_done", 256'(done_hits), 256'(0));
    check("abort_no_write", 256'(load_wr), 256'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{1, 128, 0, 'h00, -1, 128, 'h00, 'h27, 'h7F};
    vecs[1] = '{0,  40, 0, 'h01, -1,  40, 'h01, 'h28, 'h00};
    vecs[2] = '{1,   0, 0, 'h00, -1,   0, 'h00, 'h00, 'h00};
    vecs[3] = '{0, 200, 0, 'h10, -1, 128, 'h10, 'h37, 'h8F};
    vecs[4] = '{1,  64, 1, 'h00, -1,  64, 'h00, 'h27, 'h00};
    vecs[5] = '{0,  64, 0, 'hA0, 10,  64, 'hA0, 'hC7, 'h00};
    vecs[6] = '{1,  33, 0, 'h55, -1,  33, 'h55, 'h00, 'h00};

    reset = 1'b1; start = 1'b0; dest_buffer = '0; length = '0;
    in_valid = 1'b0; in_data = '0;
    load_wr = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 6) reset_mid_load();
      run_vec(vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
